// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a write FIFO.
// Frame format (length, parity, stop bits, baud) is latched per frame.
module uart_tx_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DIV_W-1:0]              div,
   input  logic [3:0]                    length,
   input  logic                          parity_en,
   input  logic                          parity_type,
   input  logic                          stop2,
   input  logic                          wr_en,
   input  logic [DATA_W-1:0]             wr_data,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          wr_err,
   output logic                          tx,
   output logic                          busy,
   output logic                          tx_done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [3:0]    LEN_MAX = 4'(DATA_W);
   localparam logic [3:0]    LEN_MIN = 4'd5;
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(FIFO_DEPTH);
   localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP1, STOP2
   } state_t;

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic              push;
   logic              pop;

   state_t            state;
   logic [DIV_W-1:0]  timer;
   logic [DIV_W-1:0]  lim_q;
   logic [3:0]        len_q;
   logic [3:0]        bit_cnt;
   logic              par_en_q;
   logic              stop2_q;
   logic              par_q;
   logic [DATA_W-1:0] shreg;

   logic [3:0]        len_eff;
   logic [DIV_W-1:0]  lim_eff;
   logic [DATA_W-1:0] len_mask;
   logic [DATA_W-1:0] head;
   logic              par_bit;
   logic              bit_end;
   logic              last_stop;
   logic              frame_end;

   assign full  = (count == CNT_MAX);
   assign empty = (count == '0);
   assign level = count;
   assign head  = mem[rd_ptr];

   assign len_eff = (length >= LEN_MIN && length <= LEN_MAX) ?
                    length : LEN_MAX;
   assign lim_eff = (div > DIV_ONE) ? div : DIV_ONE;

   // Select only the bits that will be sent for the parity sum.
   always_comb begin
      len_mask = '0;
      for (int i = 0; i < DATA_W; i++)
         len_mask[i] = (i < int'(len_eff));
   end

   // Odd parity is the inverted even-parity sum.
   assign par_bit   = (^(head & len_mask)) ^ parity_type;

   assign bit_end   = (timer == lim_q);
   assign last_stop = (state == STOP2) ||
                      (state == STOP1 && !stop2_q);
   assign frame_end = last_stop && bit_end;

   // Full is judged on pre-edge occupancy, so a pop never frees a slot
   // for a write in the same cycle.
   assign push = wr_en && !full;
   assign pop  = !empty && ((state == IDLE) || frame_end);

   // FIFO storage; contents need no reset since pointers gate reads.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= wr_data;
   end

   // FIFO pointers, occupancy and the rejected-write pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         wr_err <= 1'b0;
      end else begin
         wr_err <= wr_en && full;
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         if (push && !pop)
            count <= count + CNT_ONE;
         else if (!push && pop)
            count <= count - CNT_ONE;
      end
   end

   // Frame sequencer with registered tx, busy and tx_done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         timer    <= '0;
         lim_q    <= DIV_ONE;
         len_q    <= LEN_MAX;
         bit_cnt  <= '0;
         par_en_q <= 1'b0;
         stop2_q  <= 1'b0;
         par_q    <= 1'b0;
         shreg    <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= last_stop && (timer == lim_q - DIV_ONE);
         if (pop) begin
            state    <= START;
            timer    <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            shreg    <= head;
            len_q    <= len_eff;
            lim_q    <= lim_eff;
            par_en_q <= parity_en;
            stop2_q  <= stop2;
            par_q    <= par_bit;
         end else if (state != IDLE) begin
            if (!bit_end) begin
               timer <= timer + DIV_ONE;
            end else begin
               timer <= '0;
               unique case (state)
                  START: begin
                     state   <= DATA;
                     bit_cnt <= '0;
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
                  DATA: begin
                     if (bit_cnt == len_q - 4'd1) begin
                        if (par_en_q) begin
                           state <= PARITY;
                           tx    <= par_q;
                        end else begin
                           state <= STOP1;
                           tx    <= 1'b1;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                     end
                  end
                  PARITY: begin
                     state <= STOP1;
                     tx    <= 1'b1;
                  end
                  STOP1: begin
                     tx <= 1'b1;
                     if (stop2_q) begin
                        state <= STOP2;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end
                  STOP2: begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     tx    <= 1'b1;
                  end
                  default: begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     tx    <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo.
// Expected line waveforms are built from the frame rules per write.
module tb_uart_tx_fifo;

   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 16;
   localparam int DIV_W      = 16;
   localparam int LW         = $clog2(FIFO_DEPTH) + 1;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [DIV_W-1:0]  div;
   logic [3:0]        length;
   logic              parity_en;
   logic              parity_type;
   logic              stop2;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              full;
   logic              empty;
   logic [LW-1:0]     level;
   logic              wr_err;
   logic              tx;
   logic              busy;
   logic              tx_done;

   uart_tx_fifo #(
      .DATA_W(DATA_W),
      .FIFO_DEPTH(FIFO_DEPTH),
      .DIV_W(DIV_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .div(div),
      .length(length),
      .parity_en(parity_en),
      .parity_type(parity_type),
      .stop2(stop2),
      .wr_en(wr_en),
      .wr_data(wr_data),
      .full(full),
      .empty(empty),
      .level(level),
      .wr_err(wr_err),
      .tx(tx),
      .busy(busy),
      .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0]       bits;
      int                nbits;
      int                period;
      logic [DATA_W-1:0] data;
   } frame_t;

   frame_t exp_q[$];
   int     start_q[$];
   int     end_q[$];
   int     n_cmp = 0;
   int     n_fail = 0;
   int     cyc = 0;
   int     spur = 0;
   int     done_cnt = 0;

   bit     mon_active = 0;
   frame_t cur;
   int     pos;
   bit     bad;
   int     bad_pos;
   logic [2:0] bad_act;
   logic [2:0] bad_exp;
   logic   eb;
   logic   ed;

   // Line waveform of one frame, straight from the framing rules.
   function automatic frame_t model(input logic [DATA_W-1:0] d,
                                    input int dv, input int ln,
                                    input bit pe, input bit pt,
                                    input bit s2);
      frame_t f;
      int n;
      int len;
      bit p;
      len = (ln >= 5 && ln <= DATA_W) ? ln : DATA_W;
      f.bits = '1;
      f.data = d;
      f.period = ((dv < 1) ? 1 : dv) + 1;
      n = 0;
      f.bits[n] = 1'b0;
      n++;
      p = pt;
      for (int i = 0; i < len; i++) begin
         f.bits[n] = d[i];
         p = p ^ d[i];
         n++;
      end
      if (pe) begin
         f.bits[n] = p;
         n++;
      end
      f.bits[n] = 1'b1;
      n++;
      if (s2) begin
         f.bits[n] = 1'b1;
         n++;
      end
      f.nbits = n;
      return f;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic send(input logic [DATA_W-1:0] d);
      exp_q.push_back(model(d, int'(div), int'(length),
                            parity_en, parity_type, stop2));
      wr_en = 1'b1;
      wr_data = d;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k;
      k = 0;
      while ((busy || !empty || mon_active || exp_q.size() != 0)
             && k < budget) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (k >= budget) begin
         n_cmp++;
         n_fail++;
         $display("FAIL idle_timeout: still busy after %0d cycles, required idle",
                  budget);
         exp_q.delete();
      end
   endtask

   // Monitor: decode the line each cycle against the next expected frame.
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         mon_active = 0;
      end else begin
         if (!mon_active && tx === 1'b0) begin
            if (exp_q.size() == 0) begin
               spur++;
            end else begin
               cur = exp_q.pop_front();
               mon_active = 1;
               pos = 0;
               bad = 0;
               start_q.push_back(cyc);
            end
         end else if (!mon_active && tx_done === 1'b1) begin
            spur++;
         end
         if (mon_active) begin
            eb = cur.bits[pos / cur.period];
            ed = (pos == cur.nbits * cur.period - 1);
            if (!bad && (tx !== eb || tx_done !== ed || busy !== 1'b1)) begin
               bad = 1;
               bad_pos = pos;
               bad_act = {tx, tx_done, busy};
               bad_exp = {eb, ed, 1'b1};
            end
            if (tx_done === 1'b1)
               done_cnt++;
            pos++;
            if (pos == cur.nbits * cur.period) begin
               n_cmp++;
               if (bad) begin
                  n_fail++;
                  $display("FAIL frame data=%h: cycle %0d tx/done/busy got %b, required %b",
                           cur.data, bad_pos, bad_act, bad_exp);
               end
               end_q.push_back(cyc);
               mon_active = 0;
            end
         end
      end
   end

   initial begin
      int d0;
      int n0;
      wr_en = 1'b0;
      wr_data = '0;
      div = 16'd3;
      length = 4'd8;
      parity_en = 1'b0;
      parity_type = 1'b0;
      stop2 = 1'b0;

      #12;
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_tx_done", tx_done, 0);
      chk("rst_wr_err", wr_err, 0);
      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);
      chk("rst_level", level, 0);

      // Release mid-cycle; the write lands on the very first edge.
      #5;
      rst = 1'b1;
      send(8'hA5);
      wait_idle(200);
      chk("a5_busy_after", busy, 0);
      chk("a5_tx_after", tx, 1);
      chk("a5_level_after", level, 0);

      // Parity variants and two stop bits.
      parity_en = 1'b1;
      parity_type = 1'b1;
      send(8'h07);
      wait_idle(200);
      parity_type = 1'b0;
      send(8'h07);
      wait_idle(200);
      stop2 = 1'b1;
      send(8'h07);
      wait_idle(200);
      chk("frame12_len", end_q[$] - start_q[$] + 1, 48);
      parity_en = 1'b0;
      stop2 = 1'b0;

      // Back-to-back frames.
      d0 = done_cnt;
      n0 = start_q.size();
      send(8'h55);
      send(8'h0F);
      wait_idle(300);
      chk("b2b_gap", start_q[n0 + 1], end_q[n0] + 1);
      chk("b2b_dones", done_cnt - d0, 2);
      chk("b2b_level", level, 0);

      // Overflow while a frame holds the transmitter.
      send(8'h3C);
      @(posedge clk);
      #1;
      for (int i = 0; i < 17; i++) begin
         wr_en = 1'b1;
         wr_data = DATA_W'($urandom);
         if (i < 16)
            exp_q.push_back(model(wr_data, int'(div), int'(length),
                                  parity_en, parity_type, stop2));
         @(posedge clk);
         #1;
         if (i == 15) begin
            chk("fill_full", full, 1);
            chk("fill_level", level, 16);
            chk("fill_no_err", wr_err, 0);
         end
         if (i == 16) begin
            chk("ovf_wr_err", wr_err, 1);
            chk("ovf_level", level, 16);
         end
      end
      wr_en = 1'b0;
      @(posedge clk);
      #1;
      chk("ovf_wr_err_pulse", wr_err, 0);
      wait_idle(2000);
      chk("ovf_drain_level", level, 0);

      // Length change mid-frame affects only the next frame.
      send(8'hB3);
      repeat (12) begin
         @(posedge clk);
         #1;
      end
      length = 4'd5;
      send(8'h1C);
      wait_idle(300);
      length = 4'd8;

      // Asynchronous reset mid-frame with entries queued.
      send(8'h11);
      send(8'h22);
      send(8'h33);
      send(8'h44);
      repeat (12) begin
         @(posedge clk);
         #1;
      end
      d0 = done_cnt;
      #1;
      rst = 1'b0;
      #1;
      chk("arst_tx", tx, 1);
      chk("arst_level", level, 0);
      chk("arst_busy", busy, 0);
      chk("arst_empty", empty, 1);
      exp_q.delete();
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      chk("arst_quiet_busy", busy, 0);
      chk("arst_quiet_tx", tx, 1);
      chk("arst_quiet_level", level, 0);
      chk("arst_no_done", done_cnt - d0, 0);
      send(8'h81);
      wait_idle(200);

      // Randomized formats and bursts.
      for (int it = 0; it < 25; it++) begin
         div = DIV_W'($urandom_range(0, 3));
         length = 4'($urandom_range(0, 15));
         parity_en = 1'($urandom);
         parity_type = 1'($urandom);
         stop2 = 1'($urandom);
         repeat ($urandom_range(1, 5)) begin
            send(DATA_W'($urandom));
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk);
               #1;
            end
         end
         wait_idle(2000);
      end

      chk("no_spurious", spur, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_W, default 8: maximum data bits per frame, legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, default 16: transmit FIFO entries, power of two, at least 2.
REQ-003 Parameter DIV_W, default 16: width of the baud divisor.
REQ-004 clk  input  1  single system clock; all logic on posedge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 div  input  DIV_W  bit period minus one, in clk cycles; values 0 and 1 are both treated as 1.
REQ-007 length  input  4  data bits per frame; values outside 5..DATA_W are treated as DATA_W.
REQ-008 parity_en  input  1  1 = parity bit inserted after the data bits.
REQ-009 parity_type  input  1  1 = odd parity, 0 = even parity.
REQ-010 stop2  input  1  1 = two stop bits, 0 = one stop bit.
REQ-011 wr_en  input  1  write request for the FIFO.
REQ-012 wr_data  input  DATA_W  data to write; LSB is transmitted first.
REQ-013 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-014 empty  output  1  FIFO holds 0 entries.
REQ-015 level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-016 wr_err  output  1  one-cycle pulse when a write is rejected.
REQ-017 tx  output  1  serial line; idle level is 1.
REQ-018 busy  output  1  high while a frame is in progress (any state other than IDLE).
REQ-019 tx_done  output  1  one-cycle pulse at the end of each frame.

Function
REQ-020 Write acceptance: a write is accepted iff wr_en=1 and full=0, evaluated on pre-edge occupancy; a write while full is rejected even if a pop occurs in the same cycle.
REQ-021 Rejected write: wr_err pulses for one cycle; FIFO contents and level are unchanged.
REQ-022 Simultaneous accepted write and pop: level is unchanged and data ordering is preserved (FIFO order).
REQ-023 FSM states are IDLE, START, DATA, PARITY, STOP1, STOP2.
REQ-024 Bit timing: every bit lasts exactly max(div,1)+1 clk cycles.
REQ-025 Bit timer: counts 0..max(div,1) and resets on each bit boundary.
REQ-026 IDLE with empty=0: on the next edge, pop the head entry into the shift register and enter START; tx=0 from that edge.
REQ-027 Configuration latch: length, parity_en, parity_type, stop2 and div are latched at the pop; changes mid-frame do not affect the current frame.
REQ-028 START -> DATA, emitting data bits 0..length-1, LSB first.
REQ-029 DATA -> PARITY if parity_en, else -> STOP1.
REQ-030 PARITY -> STOP1.
REQ-031 STOP1 -> STOP2 if stop2, else end of frame.
REQ-032 STOP2 -> end of frame.
REQ-033 Stop bits drive tx=1.
REQ-034 Parity bit value: even parity = XOR of data[length-1:0]; odd parity = XNOR of data[length-1:0].
REQ-035 End of frame: tx_done pulses in the final clk cycle of the last stop bit.
REQ-036 Back-to-back frames: if the FIFO is non-empty at end of frame, the next entry is popped on that edge and START begins with no idle cycle.
REQ-037 Otherwise, at end of frame the FSM returns to IDLE with tx=1.
REQ-038 tx is driven from a register: no combinational path from any input to tx.
REQ-039 level never exceeds FIFO_DEPTH and never underflows; the read and write pointers wrap modulo FIFO_DEPTH.

Reset
REQ-040 While rst=0, asynchronously: tx=1, busy=0, tx_done=0, wr_err=0, full=0, empty=1, level=0, FSM=IDLE, timer and pointers cleared.
REQ-041 Reset asserted mid-frame aborts the frame immediately and discards all FIFO contents; no tx_done is produced.
REQ-042 First active edge after rst deasserts: the block is in IDLE; writes are accepted on that edge.

Verification
REQ-043 div=3, length=8, no parity, stop2=0; write 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 clk; tx_done 40 clk after START begins; busy low afterwards.
REQ-044 parity_en=1, parity_type=1, length=8, data 0x07 -> parity bit 0; parity_type=0 -> parity bit 1; stop2=1 -> frame 12 bits long.
REQ-045 Hold the FSM busy and write 17 entries with FIFO_DEPTH=16 -> full=1, level=16; 17th write gives a single wr_err pulse; entries 1-16 are transmitted in order.
REQ-046 Two bytes written back-to-back (0x55, 0x0F) -> stop bit of the first frame is followed directly by the start bit of the second; two tx_done pulses; level returns to 0.
REQ-047 rst=0 at bit 3 of a frame with 3 entries queued -> tx=1 and level=0 without waiting for a clk edge; no further activity until a new write.
REQ-048 Change length from 8 to 5 during the DATA state -> current frame still sends 8 bits; the next frame sends 5 bits.
